// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and its companion detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default pattern, also the target of the seq_1010 detectors.
    localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle of the pattern generator.
interface seq_pattern_gen_if #(
    parameter int PATTERN_W = 4,
    parameter int REPEAT_W  = 4
);
    logic                 i_start;
    logic                 i_abort;
    logic [PATTERN_W-1:0] i_pattern;
    logic [REPEAT_W-1:0]  i_repeat;
    logic                 o_bit;
    logic                 o_bit_valid;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_start, i_abort, i_pattern, i_repeat,
        input  o_bit, o_bit_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_pattern, i_repeat,
        output o_bit, o_bit_valid, o_busy, o_done
    );
endinterface

// File: rtl/seq_pattern_gen_timer.sv
// Per-bit hold timer: ticks on the last clock of each BIT_CYCLES-long bit period.
module seq_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] count;

    assign o_tick = i_en && (count == TERMINAL);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_en) begin
            count <= o_tick ? '0 : count + TW'(1);
        end
    end
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, repeated R times.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PATTERN_W  = 4,
    parameter int BIT_CYCLES = 4,
    parameter int REPEAT_W   = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    seq_pattern_gen_if.slave  bus
);
    localparam int BW = $clog2(PATTERN_W);
    localparam logic [BW-1:0]       LAST_BIT = BW'(PATTERN_W - 1);
    localparam logic [REPEAT_W-1:0] ONE_REP  = REPEAT_W'(1);

    state_t                state, state_next;
    logic [PATTERN_W-1:0]  shift_reg, shift_next;
    logic [PATTERN_W-1:0]  pat_copy, pat_next;
    logic [REPEAT_W-1:0]   rep_cnt, rep_next;
    logic [BW-1:0]         bit_cnt, bit_next;
    logic                  timer_clear, timer_en, tick;

    seq_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (timer_clear),
        .i_en    (timer_en),
        .o_tick  (tick)
    );

    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        pat_next    = pat_copy;
        rep_next    = rep_cnt;
        bit_next    = bit_cnt;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (bus.i_start && !bus.i_abort) begin
                    shift_next = bus.i_pattern;
                    pat_next   = bus.i_pattern;
                    rep_next   = (bus.i_repeat == '0) ? ONE_REP : bus.i_repeat;
                    bit_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.i_abort) begin
                    timer_clear = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (tick) begin
                        if (bit_cnt != LAST_BIT) begin
                            shift_next = {shift_reg[PATTERN_W-2:0], 1'b0};
                            bit_next   = bit_cnt + BW'(1);
                        end else if (rep_cnt != ONE_REP) begin
                            // Reload in the same edge so repetitions run back to back.
                            shift_next = pat_copy;
                            rep_next   = rep_cnt - REPEAT_W'(1);
                            bit_next   = '0;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                timer_clear = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                timer_clear = 1'b1;
                state_next  = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so o_bit lands one cycle after start.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            shift_reg       <= '0;
            pat_copy        <= '0;
            rep_cnt         <= '0;
            bit_cnt         <= '0;
            bus.o_bit       <= 1'b0;
            bus.o_bit_valid <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
        end else begin
            state           <= state_next;
            shift_reg       <= shift_next;
            pat_copy        <= pat_next;
            rep_cnt         <= rep_next;
            bit_cnt         <= bit_next;
            bus.o_bit       <= (state_next == SHIFT) && shift_next[PATTERN_W-1];
            bus.o_bit_valid <= (state_next == SHIFT);
            bus.o_busy      <= (state_next == SHIFT);
            bus.o_done      <= (state_next == DONE);
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected serial bits are queued at start and popped per valid cycle.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int PATTERN_W  = 4;
    localparam int BIT_CYCLES = 2;
    localparam int REPEAT_W   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seq_pattern_gen_if #(.PATTERN_W(PATTERN_W), .REPEAT_W(REPEAT_W)) bus ();

    seq_pattern_gen #(
        .PATTERN_W  (PATTERN_W),
        .BIT_CYCLES (BIT_CYCLES),
        .REPEAT_W   (REPEAT_W)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic expQ[$];
    logic expDone = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   runValid = 0;
    int   runDone = 0;
    int   hits = 0;
    logic [3:0] hist = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearRunStats();
        runValid = 0;
        runDone  = 0;
        hits     = 0;
        hist     = '0;
    endtask

    // One clock: sample just after the edge, compare against the scoreboard head.
    task automatic stepCycle();
        logic expValid;
        logic expBit;
        logic dropped;
        @(posedge clock);
        #1;
        expValid = (expQ.size() != 0);
        expBit   = expValid ? expQ[0] : 1'b0;
        checkOutput("valid", {31'd0, bus.o_bit_valid}, {31'd0, expValid});
        checkOutput("busy",  {31'd0, bus.o_busy},      {31'd0, expValid});
        checkOutput("done",  {31'd0, bus.o_done},      {31'd0, expDone});
        checkOutput("bit",   {31'd0, bus.o_bit},       {31'd0, expBit});
        if (expValid) dropped = expQ.pop_front();
        expDone = expValid && (expQ.size() == 0);
        if (bus.o_bit_valid) begin
            runValid++;
            // Non-overlapping 1010 detector sampling once per bit period.
            if (((runValid - 1) % BIT_CYCLES) == 0) begin
                hist = {hist[2:0], bus.o_bit};
                if (hist == PAT_1010) begin
                    hits++;
                    hist = '0;
                end
            end
        end
        if (bus.o_done) runDone++;
    endtask

    task automatic applyStimulus(input logic [PATTERN_W-1:0] pat, input logic [REPEAT_W-1:0] rep);
        int reps;
        reps = (rep == '0) ? 1 : int'(rep);
        clearRunStats();
        for (int r = 0; r < reps; r++)
            for (int b = PATTERN_W - 1; b >= 0; b--)
                for (int c = 0; c < BIT_CYCLES; c++)
                    expQ.push_back(pat[b]);
        bus.i_pattern = pat;
        bus.i_repeat  = rep;
        bus.i_start   = 1'b1;
        stepCycle();
        bus.i_start   = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || expDone) && n < budget) begin
            stepCycle();
            n++;
        end
        if (expQ.size() != 0 || expDone) begin
            checkOutput("timeout", 32'd1, 32'd0);
            expQ.delete();
            expDone = 1'b0;
        end
        stepCycle();
    endtask

    initial begin
        int n;
        bus.i_start   = 1'b0;
        bus.i_abort   = 1'b0;
        bus.i_pattern = '0;
        bus.i_repeat  = '0;

        stepCycle();
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) stepCycle();

        $display("[TB] single pattern");
        applyStimulus(PAT_1010, 4'd1);
        waitIdle(40);
        checkOutput("single_valid_cycles", runValid, 8);
        checkOutput("single_done_count", runDone, 1);

        $display("[TB] three repetitions");
        applyStimulus(PAT_1010, 4'd3);
        bus.i_pattern = 4'b0110;
        bus.i_repeat  = 4'd7;
        waitIdle(80);
        checkOutput("rep3_valid_cycles", runValid, 24);
        checkOutput("rep3_done_count", runDone, 1);
        checkOutput("rep3_hits", hits, 3);

        $display("[TB] zero repeat");
        applyStimulus(4'b1101, 4'd0);
        waitIdle(40);
        checkOutput("rep0_valid_cycles", runValid, 8);
        checkOutput("rep0_done_count", runDone, 1);

        $display("[TB] abort");
        applyStimulus(PAT_1010, 4'd2);
        n = 0;
        while (runValid < 5 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("abort_reach_5", runValid, 5);
        bus.i_abort = 1'b1;
        expQ.delete();
        expDone = 1'b0;
        stepCycle();
        bus.i_abort = 1'b0;
        stepCycle();
        checkOutput("abort_no_done", runDone, 0);
        applyStimulus(4'b1001, 4'd1);
        waitIdle(40);
        checkOutput("after_abort_valid_cycles", runValid, 8);
        checkOutput("after_abort_done_count", runDone, 1);

        $display("[TB] abort with start in idle");
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        stepCycle();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        stepCycle();

        $display("[TB] start while busy");
        applyStimulus(PAT_1010, 4'd1);
        stepCycle();
        stepCycle();
        bus.i_pattern = 4'b0101;
        bus.i_repeat  = 4'd5;
        bus.i_start   = 1'b1;
        stepCycle();
        bus.i_start   = 1'b0;
        waitIdle(40);
        checkOutput("restart_valid_cycles", runValid, 8);
        checkOutput("restart_done_count", runDone, 1);

        $display("[TB] reset mid-transmission");
        applyStimulus(4'b1111, 4'd2);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        expQ.delete();
        expDone = 1'b0;
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("reset_no_done", runDone, 0);
        applyStimulus(4'b0011, 4'd1);
        waitIdle(40);
        checkOutput("after_reset_valid_cycles", runValid, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
